// File: rtl/dmem_arbiter_pkg.sv
// Shared widths, word constants and owner encodings for the data-memory arbiter.
package dmem_arbiter_pkg;

   localparam int instWidth    = 32;
   localparam int regAddrWidth = 32;

   localparam logic [instWidth-1:0] zeroWord = '0;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CORE = 2'd1,
      OWN_FFT  = 2'd2
   } owner_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core LSU and the FFT engine.
// Core has priority except inside a locked FFT burst, which is capped at MAX_BURST beats while the core waits.
//
// state    | meaning
// OWN_NONE | nothing granted last cycle; fresh arbitration, core first
// OWN_CORE | core granted last cycle
// OWN_FFT  | FFT granted last cycle, or FFT burst preempted by one forced core slot
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 8,
   parameter int STALL_W   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    core_req,
   input  logic                    core_we,
   input  logic [regAddrWidth-1:0] core_addr,
   input  logic [instWidth-1:0]    core_wdata,
   output logic [instWidth-1:0]    core_rdata,
   output logic                    core_stall,
   input  logic                    fft_req,
   input  logic                    fft_lock,
   input  logic                    fft_we,
   input  logic [regAddrWidth-1:0] fft_addr,
   input  logic [instWidth-1:0]    fft_wdata,
   output logic                    fft_gnt,
   output logic [instWidth-1:0]    fft_rdata,
   output logic                    mem_wena,
   output logic                    mem_rena,
   output logic [regAddrWidth-1:0] mem_addr,
   output logic [instWidth-1:0]    mem_wdata,
   input  logic [instWidth-1:0]    mem_data_i,
   output logic [STALL_W-1:0]      stall_cnt
);

   localparam int              BEAT_W   = $clog2(MAX_BURST + 1);
   localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST);

   owner_t              owner, owner_nxt, gnt;
   logic [BEAT_W-1:0]   beat_cnt, beat_nxt;
   logic [STALL_W-1:0]  stall_q;
   logic                fft_hold;
   logic                forced_slot;

   always_ff @(posedge clk) begin
      if (!rst) begin
         owner    <= OWN_NONE;
         beat_cnt <= '0;
         stall_q  <= '0;
      end else begin
         owner    <= owner_nxt;
         beat_cnt <= beat_nxt;
         if (core_stall && (stall_q != {STALL_W{1'b1}}))
            stall_q <= stall_q + 1'b1;
      end
   end

   assign stall_cnt = stall_q;

   always_comb begin
      gnt         = OWN_NONE;
      owner_nxt   = OWN_NONE;
      beat_nxt    = '0;
      fft_hold    = (owner == OWN_FFT) && fft_lock && fft_req
                    && !(core_req && (beat_cnt >= BEAT_MAX));
      forced_slot = 1'b0;

      if (rst) begin
         if (fft_hold)
            gnt = OWN_FFT;
         else if (core_req)
            gnt = OWN_CORE;
         else if (fft_req)
            gnt = OWN_FFT;
      end

      // A core slot carved out of a still-locked burst keeps the FFT as owner,
      // so the burst resumes on the very next cycle.
      forced_slot = (gnt == OWN_CORE) && (owner == OWN_FFT) && fft_lock && fft_req;
      owner_nxt   = forced_slot ? OWN_FFT : gnt;

      if (gnt == OWN_FFT) begin
         if (core_req && (beat_cnt < BEAT_MAX))
            beat_nxt = beat_cnt + 1'b1;
         else
            beat_nxt = beat_cnt;
      end
   end

   always_comb begin
      mem_wena   = 1'b0;
      mem_rena   = 1'b0;
      mem_addr   = '0;
      mem_wdata  = zeroWord;
      core_rdata = zeroWord;
      fft_rdata  = zeroWord;
      fft_gnt    = 1'b0;
      core_stall = 1'b0;

      case (gnt)
         OWN_CORE: begin
            mem_wena  = core_we;
            mem_rena  = !core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            if (!core_we)
               core_rdata = mem_data_i;
         end
         OWN_FFT: begin
            fft_gnt   = 1'b1;
            mem_wena  = fft_we;
            mem_rena  = !fft_we;
            mem_addr  = fft_addr;
            mem_wdata = fft_wdata;
            if (!fft_we)
               fft_rdata = mem_data_i;
         end
         default: ;
      endcase

      core_stall = rst && core_req && (gnt != OWN_CORE);
   end

endmodule
